// File: rtl/custom_apb_master_if.sv
// ---------------------------------------------------------------------------
// custom_apb_master_if
// Bundles the command stream, the response stream and the APB3 bus of
// custom_apb_master.
//   master modport : the APB initiator (drives cmd_ready, rsp_*, P* requests)
//   slave modport  : the environment (requester, response sink, APB slave)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata   command channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout  response channel
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR  APB3 bus
// ---------------------------------------------------------------------------
interface custom_apb_master_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [31:0]          cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;

    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic [31:0]          PWDATA;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/custom_apb_master.sv
// ---------------------------------------------------------------------------
// custom_apb_master
// APB3 initiator: turns a valid/ready command stream into single APB
// read/write transfers (one outstanding) and returns read data / error status
// on a valid/ready response channel. Honours PREADY wait states and PSLVERR.
// Ports:
//   PCLK    clock, rising edge
//   PRESET  synchronous active-high reset
//   bus     custom_apb_master_if.master (command, response and APB signals)
// Parameters:
//   ADDRWIDTH       APB address width (PADDR[1:0] always 0)
//   TIMEOUT_CYCLES  PREADY-low ACCESS cycles before abort, 1..255
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   -> an 8-bit wait counter aborts a stalled ACCESS phase
//   undefined -> ACCESS waits indefinitely, rsp_timeout is constant 0
// ---------------------------------------------------------------------------
module custom_apb_master #(
    parameter int ADDRWIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    custom_apb_master_if.master        bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("custom_apb_master: TIMEOUT_CYCLES must be within 1..255");
    end

    state_t               state_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [ADDRWIDTH-1:0] paddr_q;
    logic [31:0]          pwdata_q;
    logic                 rsp_valid_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_err_q;

    // Byte lanes are never addressed; PADDR is always word aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.cmd_addr[1:0];

`ifdef APB_MASTER_TIMEOUT_EN
    // Abort fires on the edge that would make the count reach the limit.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q;
    logic       rsp_timeout_q;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        pwrite_q  <= bus.cmd_write;
                        paddr_q   <= {bus.cmd_addr[ADDRWIDTH-1:2], 2'b00};
                        pwdata_q  <= bus.cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ACCESS: begin
                    // PREADY is checked first so completion wins over timeout.
                    if (bus.PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? 32'h0 : bus.PRDATA;
                        rsp_err_q   <= bus.PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state_q     <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt_q == WAIT_LIMIT) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= 32'h0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_custom_apb_master.sv
// ---------------------------------------------------------------------------
// tb_custom_apb_master
// Bench for custom_apb_master. Transactions are described at transfer level
// (direction, address, data, number of wait states, slave error, response
// back-pressure); expected bus timing and response contents are derived from
// those parameters with plain arithmetic and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_custom_apb_master;
    localparam int AW = 12;
    localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    custom_apb_master_if #(.ADDRWIDTH(AW)) ifc ();

    custom_apb_master #(
        .ADDRWIDTH      (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transfer. Starts and ends just after a falling edge.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input bit err, input int hold);
        bit             timed_out;
        int             pen_exp;
        int             k, pen_n, psel_n;
        bit             stable_ok, proto_ok, hold_ok;
        logic [AW-1:0]  exp_addr;
        logic [31:0]    exp_rdata;
        bit             exp_err;

        timed_out = TO_EN && (waits >= TO);
        pen_exp   = timed_out ? TO : waits + 1;
        exp_addr  = addr & ~AW'(3);
        exp_rdata = (timed_out || wr) ? 32'h0 : rd;
        exp_err   = timed_out ? 1'b1 : err;

        check("cmd_ready_idle", ifc.cmd_ready, 1);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = wr;
        ifc.cmd_addr  = addr;
        ifc.cmd_wdata = wd;
        @(posedge PCLK); @(negedge PCLK);
        // Scramble command inputs to show the transfer uses latched values.
        ifc.cmd_valid = 1'b0;
        ifc.cmd_write = ~wr;
        ifc.cmd_addr  = AW'($urandom);
        ifc.cmd_wdata = $urandom;

        k = 1; pen_n = 0; psel_n = 0; stable_ok = 1'b1; proto_ok = 1'b1;
        while (!ifc.rsp_valid && k < 300) begin
            if (ifc.PENABLE && !ifc.PSEL) proto_ok = 1'b0;
            if (ifc.cmd_ready) proto_ok = 1'b0;
            if (ifc.PSEL) begin
                psel_n++;
                if (ifc.PADDR !== exp_addr || ifc.PWRITE !== wr || ifc.PWDATA !== wd)
                    stable_ok = 1'b0;
            end
            if (ifc.PSEL && ifc.PENABLE) begin
                ifc.PREADY  = (pen_n == waits);
                ifc.PRDATA  = ifc.PREADY ? rd : $urandom;
                ifc.PSLVERR = ifc.PREADY ? err : 1'($urandom);
                pen_n++;
            end else begin
                ifc.PREADY  = 1'($urandom);
                ifc.PRDATA  = $urandom;
                ifc.PSLVERR = 1'($urandom);
            end
            @(posedge PCLK); @(negedge PCLK);
            k++;
        end
        ifc.PREADY  = 1'b0;
        ifc.PSLVERR = 1'b0;
        check("rsp_within_budget", ifc.rsp_valid, 1);
        check("latency", k, pen_exp + 2);
        check("penable_cycles", pen_n, pen_exp);
        check("psel_cycles", psel_n, pen_exp + 1);
        check("addr_data_stable", stable_ok, 1);
        check("protocol", proto_ok, 1);
        check("psel_after_done", {ifc.PSEL, ifc.PENABLE}, 0);
        check("rsp_rdata", ifc.rsp_rdata, exp_rdata);
        check("rsp_err", ifc.rsp_err, exp_err);
        check("rsp_timeout", ifc.rsp_timeout, timed_out);

        // Back-pressure: response stays put and a new command is refused.
        ifc.cmd_valid = 1'b1;
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (!ifc.rsp_valid || ifc.rsp_rdata !== exp_rdata || ifc.rsp_err !== exp_err ||
                ifc.rsp_timeout !== timed_out || ifc.cmd_ready || ifc.PSEL)
                hold_ok = 1'b0;
        end
        ifc.cmd_valid = 1'b0;
        check("rsp_hold", hold_ok, 1);

        ifc.rsp_ready = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        ifc.rsp_ready = 1'b0;
        check("rsp_consumed", {ifc.rsp_valid, ifc.cmd_ready, ifc.PSEL}, 3'b010);
        check("rsp_retained", {ifc.rsp_rdata, ifc.rsp_err, ifc.rsp_timeout},
              {exp_rdata, exp_err, timed_out});
    endtask

    initial begin
        bit rst_ok;
        ifc.cmd_valid = 1'b0; ifc.cmd_write = 1'b0; ifc.cmd_addr = '0; ifc.cmd_wdata = '0;
        ifc.rsp_ready = 1'b0; ifc.PRDATA = '0; ifc.PREADY = 1'b0; ifc.PSLVERR = 1'b0;

        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        check("rst_apb", {ifc.PSEL, ifc.PENABLE, ifc.PWRITE, ifc.PADDR, ifc.PWDATA}, 0);
        check("rst_rsp", {ifc.rsp_valid, ifc.rsp_rdata, ifc.rsp_err, ifc.rsp_timeout}, 0);
        check("rst_cmd_ready", ifc.cmd_ready, 1);

        // Directed transfers
        run_txn(1'b1, 12'h006, 32'h0000_0001, 0, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn(1'b0, 12'h000, 32'h1234_5678, 3, 32'hA5A5_0001, 1'b0, 0);
        run_txn(1'b0, 12'h3F1, 32'h0, 1, 32'h0BAD_F00D, 1'b1, 5);

        // Reset in the middle of ACCESS
        ifc.cmd_valid = 1'b1; ifc.cmd_write = 1'b0; ifc.cmd_addr = 12'h120;
        @(posedge PCLK); @(negedge PCLK);
        ifc.cmd_valid = 1'b0; ifc.PREADY = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        check("pre_rst_access", {ifc.PSEL, ifc.PENABLE}, 2'b11);
        PRESET = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        PRESET = 1'b0;
        check("rst_mid_apb", {ifc.PSEL, ifc.PENABLE, ifc.rsp_valid, ifc.cmd_ready}, 4'b0001);
        rst_ok = 1'b1;
        ifc.PREADY = 1'b1;
        repeat (3) begin
            @(posedge PCLK); @(negedge PCLK);
            if (ifc.rsp_valid || ifc.PSEL) rst_ok = 1'b0;
        end
        ifc.PREADY = 1'b0;
        check("rst_mid_no_rsp", rst_ok, 1);
        run_txn(1'b1, 12'h044, 32'hCAFE_0042, 0, 32'h0, 1'b0, 1);

        // Long waits: ready on the 16th ACCESS cycle completes normally
        run_txn(1'b0, 12'h210, 32'h0, TO - 1, 32'h1357_9BDF, 1'b0, 0);
`ifdef APB_MASTER_TIMEOUT_EN
        run_txn(1'b0, 12'h300, 32'h0, TO, 32'hFFFF_FFFF, 1'b0, 0);
        run_txn(1'b1, 12'h304, 32'h5555_AAAA, TO + 20, 32'h0, 1'b0, 2);
        run_txn(1'b0, 12'h308, 32'h0, 2, 32'h7777_0007, 1'b0, 0);
`else
        run_txn(1'b0, 12'h300, 32'h0, TO + 10, 32'h2468_ACE0, 1'b0, 0);
`endif

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), AW'($urandom), $urandom,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 24)) : int'($urandom_range(0, 5)),
                    $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/custom_apb_master.md
Name: custom_apb_master

Overview:
- APB3 initiator that converts a simple valid/ready command stream into single APB read/write transfers toward the peripheral slaves.
- Returns read data and error status on a valid/ready response channel.
- Sits between the bus-bridge/test-sequencer logic and the APB peripherals: buzzer, GPIO and similar custom slaves.
- One transfer outstanding at a time. Honours PREADY wait states and PSLVERR.

Parameters:
ADDRWIDTH, 12, APB address width; PADDR[1:0] always driven 0.
TIMEOUT_CYCLES, 16, consecutive PREADY-low ACCESS cycles before abort (used only with the optional feature); legal range 1..255.

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDRWIDTH  byte address
cmd_wdata  input  32  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_rdata  output  32  read data; 0 for writes
rsp_err  output  1  PSLVERR seen or timeout
rsp_timeout  output  1  transfer aborted by timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDRWIDTH  APB address
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready, which equals (state==IDLE).
- Reset (PRESET high at an edge): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0. cmd_ready=1 after reset.
- IDLE: on cmd_valid & cmd_ready at an edge:
  - latch PWRITE=cmd_write, PADDR={cmd_addr[ADDRWIDTH-1:2],2'b00}, PWDATA=cmd_wdata;
  - PSEL=1, PENABLE=0; go to SETUP.
  - cmd_valid outside IDLE is ignored; the requester holds it.
- SETUP: exactly one cycle. Next edge sets PENABLE=1 and goes to ACCESS.
- ACCESS: PSEL=PENABLE=1. Stays while PREADY=0.
  - On an edge with PREADY=1: PSEL=PENABLE=0, rsp_valid=1.
  - rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err=PSLVERR; rsp_timeout=0; go to RESP.
  - PSLVERR is sampled only in this completing cycle.
- RESP: rsp_* held stable while rsp_valid=1. On rsp_ready at an edge: rsp_valid=0, go to IDLE. rsp_rdata, rsp_err and rsp_timeout retain their values until the next completion.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS, and hold until the next accepted command.
- Latency, zero wait states:
  - command accepted at edge N;
  - SETUP during cycle N..N+1, ACCESS during N+1..N+2;
  - rsp_valid high after edge N+2;
  - with rsp_ready tied high, the next command is accepted at edge N+4.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- Reset mid-transfer: PSEL and PENABLE drop at the reset edge. No response is produced; an in-flight command is lost.
- PENABLE is never 1 while PSEL=0. PSEL never drops before PREADY=1 except on reset or timeout.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - 8-bit wait counter, cleared on entry to ACCESS, incremented on each ACCESS edge with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES and PREADY is still 0 at that edge: PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
  - PREADY=1 on the same edge the limit is reached means normal completion wins.
- Undefined: no counter is built, ACCESS waits indefinitely, and rsp_timeout is constant 0.

Test Plan:
- Reset held 2 cycles, then released -> all APB outputs 0, cmd_ready=1, rsp_valid=0.
- Write addr 0x006, data 0x0000_0001, PREADY=1 -> PADDR=0x004, PWRITE=1, one SETUP and one ACCESS cycle; rsp_valid after edge N+2 with rsp_err=0, rsp_rdata=0.
- Read 0x000, PREADY low for 3 ACCESS cycles, PRDATA=0xA5A5_0001 on the ready cycle -> PENABLE high 4 cycles, rsp_rdata=0xA5A5_0001, address/data stable throughout.
- Read with PSLVERR=1 on the completing cycle and rsp_ready held low 5 cycles -> rsp_err=1, response stable 5 cycles, cmd_ready=0 until consumed; a cmd_valid presented meanwhile is not accepted.
- Reset asserted during ACCESS -> PSEL/PENABLE 0 after that edge, no rsp_valid; a fresh write then completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck 0 -> abort after the 16th wait edge with rsp_err=1, rsp_timeout=1. Repeat with PREADY=1 on the 16th cycle -> normal completion, rsp_timeout=0.
